// File: rtl/jtag_tap_multi_dr_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_multi_dr_if
// Brief    : Serial JTAG pins plus parallel user-DR channels of the multi-DR TAP.
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_tap_multi_dr_if #(
  parameter int IR_WIDTH = 5,
  parameter int NUM_DR   = 4,
  parameter int DR_WIDTH = 32
);
  logic                         tms;
  logic                         tdi;
  logic                         tdo;
  logic                         tdo_en;
  logic [3:0]                   tap_state;
  logic [IR_WIDTH-1:0]          ir_out;
  logic [NUM_DR*DR_WIDTH-1:0]   dr_in;
  logic [NUM_DR*DR_WIDTH-1:0]   dr_out;
  logic [NUM_DR-1:0]            dr_upd;

  // Board / on-chip test logic side
  modport master (
    output tms, tdi, dr_in,
    input  tdo, tdo_en, tap_state, ir_out, dr_out, dr_upd
  );

  // TAP side
  modport slave (
    input  tms, tdi, dr_in,
    output tdo, tdo_en, tap_state, ir_out, dr_out, dr_upd
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_multi_dr.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_multi_dr
// Brief    : IEEE 1149.1 TAP with BYPASS, IDCODE and NUM_DR user data registers.
//            Macro JTAG_TAP_DR_CAPTURE_IN_EN: user Capture-DR loads dr_in
//            instead of looping back dr_out.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_multi_dr #(
  parameter int          IR_WIDTH   = 5,
  parameter int          NUM_DR     = 4,
  parameter int          DR_WIDTH   = 32,
  parameter logic [31:0] IDCODE_VAL = 32'hCAFEF00D,
  parameter int          USER_BASE  = 8
) (
  input wire                 tck,
  input wire                 trst_n,
  jtag_tap_multi_dr_if.slave bus
);

  localparam logic [3:0] S_EX2DR   = 4'h0;
  localparam logic [3:0] S_EX1DR   = 4'h1;
  localparam logic [3:0] S_SHDR    = 4'h2;
  localparam logic [3:0] S_PAUSEDR = 4'h3;
  localparam logic [3:0] S_SELIR   = 4'h4;
  localparam logic [3:0] S_UPDDR   = 4'h5;
  localparam logic [3:0] S_CAPDR   = 4'h6;
  localparam logic [3:0] S_SELDR   = 4'h7;
  localparam logic [3:0] S_EX2IR   = 4'h8;
  localparam logic [3:0] S_EX1IR   = 4'h9;
  localparam logic [3:0] S_SHIR    = 4'hA;
  localparam logic [3:0] S_PAUSEIR = 4'hB;
  localparam logic [3:0] S_RTI     = 4'hC;
  localparam logic [3:0] S_UPDIR   = 4'hD;
  localparam logic [3:0] S_CAPIR   = 4'hE;
  localparam logic [3:0] S_TLR     = 4'hF;

  localparam int                  UIDX_W    = (NUM_DR > 1) ? $clog2(NUM_DR) : 1;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

  logic [3:0]                 state_q,     state_d;
  logic [IR_WIDTH-1:0]        ir_sr_q,     ir_sr_d;
  logic [IR_WIDTH-1:0]        ir_q,        ir_d;
  logic                       bypass_q,    bypass_d;
  logic [31:0]                idcode_sr_q, idcode_sr_d;
  logic [DR_WIDTH-1:0]        user_sr_q,   user_sr_d;
  logic [NUM_DR*DR_WIDTH-1:0] dr_out_q,    dr_out_d;
  logic [NUM_DR-1:0]          dr_upd_q,    dr_upd_d;
  logic                       tdo_q,       tdo_d;
  logic                       tdo_en_q,    tdo_en_d;

  logic                       sel_idcode;
  logic                       sel_user;
  logic [UIDX_W-1:0]          user_idx;
  logic [NUM_DR*DR_WIDTH-1:0] cap_src;
  logic [DR_WIDTH-1:0]        user_cap;

`ifdef JTAG_TAP_DR_CAPTURE_IN_EN
  assign cap_src = bus.dr_in;
`else
  logic unused_dr_in;
  assign cap_src      = dr_out_q;
  assign unused_dr_in = ^bus.dr_in;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:     state_d = bus.tms ? S_TLR     : S_RTI;
      S_RTI:     state_d = bus.tms ? S_SELDR   : S_RTI;
      S_SELDR:   state_d = bus.tms ? S_SELIR   : S_CAPDR;
      S_CAPDR:   state_d = bus.tms ? S_EX1DR   : S_SHDR;
      S_SHDR:    state_d = bus.tms ? S_EX1DR   : S_SHDR;
      S_EX1DR:   state_d = bus.tms ? S_UPDDR   : S_PAUSEDR;
      S_PAUSEDR: state_d = bus.tms ? S_EX2DR   : S_PAUSEDR;
      S_EX2DR:   state_d = bus.tms ? S_UPDDR   : S_SHDR;
      S_UPDDR:   state_d = bus.tms ? S_SELDR   : S_RTI;
      S_SELIR:   state_d = bus.tms ? S_TLR     : S_CAPIR;
      S_CAPIR:   state_d = bus.tms ? S_EX1IR   : S_SHIR;
      S_SHIR:    state_d = bus.tms ? S_EX1IR   : S_SHIR;
      S_EX1IR:   state_d = bus.tms ? S_UPDIR   : S_PAUSEIR;
      S_PAUSEIR: state_d = bus.tms ? S_EX2IR   : S_PAUSEIR;
      S_EX2IR:   state_d = bus.tms ? S_UPDIR   : S_SHIR;
      S_UPDIR:   state_d = bus.tms ? S_SELDR   : S_RTI;
      default:   state_d = S_TLR;
    endcase
  end

  // All-ones is always BYPASS, even if the user window would cover it
  always_comb begin
    sel_idcode = (ir_q == IR_IDCODE);
    sel_user   = 1'b0;
    user_idx   = '0;
    user_cap   = '0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (!sel_idcode && (ir_q != '1) && (ir_q == IR_WIDTH'(USER_BASE + k))) begin
        sel_user = 1'b1;
        user_idx = UIDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_DR; k++) begin
      if (user_idx == UIDX_W'(k)) begin
        user_cap = cap_src[k*DR_WIDTH +: DR_WIDTH];
      end
    end
  end

  always_comb begin
    ir_sr_d     = ir_sr_q;
    ir_d        = ir_q;
    bypass_d    = bypass_q;
    idcode_sr_d = idcode_sr_q;
    user_sr_d   = user_sr_q;
    dr_out_d    = dr_out_q;
    dr_upd_d    = '0;
    case (state_q)
      S_CAPIR: ir_sr_d = IR_IDCODE;
      S_SHIR:  ir_sr_d = {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
      S_UPDIR: ir_d    = ir_sr_q;
      S_CAPDR: begin
        if (sel_user)        user_sr_d   = user_cap;
        else if (sel_idcode) idcode_sr_d = IDCODE_VAL;
        else                 bypass_d    = 1'b0;
      end
      S_SHDR: begin
        if (sel_user) begin
          user_sr_d               = user_sr_q >> 1;
          user_sr_d[DR_WIDTH-1]   = bus.tdi;
        end else if (sel_idcode) begin
          idcode_sr_d = {bus.tdi, idcode_sr_q[31:1]};
        end else begin
          bypass_d = bus.tdi;
        end
      end
      S_UPDDR: begin
        for (int k = 0; k < NUM_DR; k++) begin
          if (sel_user && (user_idx == UIDX_W'(k))) begin
            dr_out_d[k*DR_WIDTH +: DR_WIDTH] = user_sr_q;
            dr_upd_d[k]                      = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_TLR) ir_d = IR_IDCODE;
  end

  // TDO is launched on the falling edge and holds outside the shift states
  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = (state_q == S_SHDR) || (state_q == S_SHIR);
    if (state_q == S_SHIR) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == S_SHDR) begin
      if (sel_user)        tdo_d = user_sr_q[0];
      else if (sel_idcode) tdo_d = idcode_sr_q[0];
      else                 tdo_d = bypass_q;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= S_TLR;
      ir_sr_q     <= '0;
      ir_q        <= IR_IDCODE;
      bypass_q    <= 1'b0;
      idcode_sr_q <= '0;
      user_sr_q   <= '0;
      dr_out_q    <= '0;
      dr_upd_q    <= '0;
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_q        <= ir_d;
      bypass_q    <= bypass_d;
      idcode_sr_q <= idcode_sr_d;
      user_sr_q   <= user_sr_d;
      dr_out_q    <= dr_out_d;
      dr_upd_q    <= dr_upd_d;
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign bus.tdo       = tdo_q;
  assign bus.tdo_en    = tdo_en_q;
  assign bus.tap_state = state_q;
  assign bus.ir_out    = ir_q;
  assign bus.dr_out    = dr_out_q;
  assign bus.dr_upd    = dr_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_multi_dr.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_multi_dr
// Brief    : Directed plus randomized bench for jtag_tap_multi_dr against a
//            table-driven TAP model. Honours JTAG_TAP_DR_CAPTURE_IN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_multi_dr;

  localparam int          IR_WIDTH   = 5;
  localparam int          NUM_DR     = 4;
  localparam int          DR_WIDTH   = 32;
  localparam int          USER_BASE  = 8;
  localparam logic [31:0] IDCODE_VAL = 32'hCAFEF00D;

  logic tck    = 1'b0;
  logic trst_n = 1'b0;

  jtag_tap_multi_dr_if #(.IR_WIDTH(IR_WIDTH), .NUM_DR(NUM_DR), .DR_WIDTH(DR_WIDTH)) intf ();

  jtag_tap_multi_dr #(
    .IR_WIDTH  (IR_WIDTH),
    .NUM_DR    (NUM_DR),
    .DR_WIDTH  (DR_WIDTH),
    .IDCODE_VAL(IDCODE_VAL),
    .USER_BASE (USER_BASE)
  ) dut (
    .tck   (tck),
    .trst_n(trst_n),
    .bus   (intf.slave)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // TMS graph as successor tables indexed by state code
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic [3:0]          m_state;
  logic [IR_WIDTH-1:0] m_ir;
  logic [IR_WIDTH-1:0] m_ir_sr;
  logic [63:0]         m_sr;
  int                  m_len;
  logic [DR_WIDTH-1:0] m_dr_out [NUM_DR];
  logic [NUM_DR-1:0]   m_upd;
  logic                m_tdo;
  logic                m_tdo_en;

  // -2 = IDCODE, -1 = BYPASS, k >= 0 = USER_k
  function automatic int path_of(input logic [IR_WIDTH-1:0] ir);
    int v;
    v = int'(ir);
    if (v == 1) return -2;
    if (v == (1 << IR_WIDTH) - 1) return -1;
    if (v >= USER_BASE && v < USER_BASE + NUM_DR) return v - USER_BASE;
    return -1;
  endfunction

  task automatic model_reset();
    m_state  = 4'hF;
    m_ir     = IR_WIDTH'(1);
    m_ir_sr  = '0;
    m_sr     = '0;
    m_len    = 1;
    m_upd    = '0;
    m_tdo    = 1'b0;
    m_tdo_en = 1'b0;
    for (int k = 0; k < NUM_DR; k++) m_dr_out[k] = '0;
  endtask

  task automatic model_rise(input logic t, input logic d);
    int p;
    p     = path_of(m_ir);
    m_upd = '0;
    if (m_state == 4'hE) m_ir_sr = IR_WIDTH'(1);
    if (m_state == 4'hA) m_ir_sr = {d, m_ir_sr[IR_WIDTH-1:1]};
    if (m_state == 4'hD) m_ir = m_ir_sr;
    if (m_state == 4'h6) begin
      if (p >= 0) begin
        m_len = DR_WIDTH;
`ifdef JTAG_TAP_DR_CAPTURE_IN_EN
        m_sr  = 64'(intf.dr_in[p*DR_WIDTH +: DR_WIDTH]);
`else
        m_sr  = 64'(m_dr_out[p]);
`endif
      end else if (p == -2) begin
        m_len = 32;
        m_sr  = 64'(IDCODE_VAL);
      end else begin
        m_len = 1;
        m_sr  = '0;
      end
    end
    if (m_state == 4'h2) begin
      m_sr          = m_sr >> 1;
      m_sr[m_len-1] = d;
    end
    if (m_state == 4'h5 && p >= 0) begin
      m_dr_out[p] = m_sr[DR_WIDTH-1:0];
      m_upd[p]    = 1'b1;
    end
    m_state = t ? nxt1[m_state] : nxt0[m_state];
    if (m_state == 4'hF) m_ir = IR_WIDTH'(1);
  endtask

  task automatic model_fall();
    m_tdo_en = (m_state == 4'h2) || (m_state == 4'hA);
    if (m_state == 4'h2) m_tdo = m_sr[0];
    if (m_state == 4'hA) m_tdo = m_ir_sr[0];
  endtask

  task automatic step(input logic t, input logic d);
    intf.tms = t;
    intf.tdi = d;
    @(posedge tck);
    model_rise(t, d);
    #1;
    check_val("tap_state", 64'(intf.tap_state), 64'(m_state));
    check_val("ir_out", 64'(intf.ir_out), 64'(m_ir));
    check_val("dr_upd", 64'(intf.dr_upd), 64'(m_upd));
    for (int k = 0; k < NUM_DR; k++)
      check_val($sformatf("dr_out%0d", k), 64'(intf.dr_out[k*DR_WIDTH +: DR_WIDTH]), 64'(m_dr_out[k]));
    @(negedge tck);
    model_fall();
    #1;
    check_val("tdo", 64'(intf.tdo), 64'(m_tdo));
    check_val("tdo_en", 64'(intf.tdo_en), 64'(m_tdo_en));
  endtask

  task automatic pulse_reset();
    #2 trst_n = 1'b0;
    #1;
    check_val("rst_state", 64'(intf.tap_state), 64'h0F);
    check_val("rst_ir", 64'(intf.ir_out), 64'h01);
    check_val("rst_dr_out", 64'(|intf.dr_out), 64'h0);
    check_val("rst_dr_upd", 64'(intf.dr_upd), 64'h0);
    check_val("rst_tdo", 64'(intf.tdo), 64'h0);
    check_val("rst_tdo_en", 64'(intf.tdo_en), 64'h0);
    model_reset();
    @(negedge tck);
    #1 trst_n = 1'b1;
  endtask

  task automatic shift_bits(input logic [63:0] data, input int n, output logic [63:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got[i] = intf.tdo;
      step(i == n - 1, data[i]);
    end
  endtask

  task automatic goto_tlr_rti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom));
    check_val("tlr_5_ones", 64'(intf.tap_state), 64'h0F);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IR_WIDTH-1:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < IR_WIDTH; i++) step(i == IR_WIDTH - 1, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [63:0] data, input int n, output logic [63:0] got);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(data, n, got);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0]         got;
    logic [31:0]         w;
    logic [7:0]          a5;
    logic [IR_WIDTH-1:0] irv;

    intf.tms   = 1'b1;
    intf.tdi   = 1'b0;
    intf.dr_in = '0;
    model_reset();
    @(negedge tck);
    #1;
    pulse_reset();

    // IDCODE readout straight out of reset
    step(1'b0, 1'b0); check_val("seq_rti",   64'(intf.tap_state), 64'h0C);
    step(1'b1, 1'b0); check_val("seq_seldr", 64'(intf.tap_state), 64'h07);
    step(1'b0, 1'b0); check_val("seq_capdr", 64'(intf.tap_state), 64'h06);
    step(1'b0, 1'b0); check_val("seq_shdr",  64'(intf.tap_state), 64'h02);
    shift_bits({$urandom, $urandom}, 32, got);
    check_val("idcode", got, 64'hCAFEF00D);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // BYPASS: one-cycle delay, leading captured zero
    load_ir(5'h1F);
    a5 = 8'hA5;
    scan_dr(64'(a5), 8, got);
    check_val("bypass_tdo", got, 64'(8'(a5 << 1)));
    check_val("bypass_noupd", 64'(intf.dr_upd), 64'h0);

    // USER_2 write
    load_ir(5'h0A);
    scan_dr(64'h12345678, 32, got);
    check_val("user2_pulse", 64'(intf.dr_upd), 64'h4);
    check_val("user2_dr_out", 64'(intf.dr_out[2*DR_WIDTH +: DR_WIDTH]), 64'h12345678);
    step(1'b0, 1'b0);
    check_val("user2_pulse_end", 64'(intf.dr_upd), 64'h0);

    // USER_1 with a Pause-DR break half way
    load_ir(5'h09);
    w = $urandom;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(64'(w), 16, got);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(64'(w >> 16), 16, got);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_val("user1_pause", 64'(intf.dr_out[1*DR_WIDTH +: DR_WIDTH]), 64'(w));

    // USER_0 capture source
    load_ir(5'h08);
    w = $urandom;
    scan_dr(64'(w), 32, got);
    intf.dr_in[31:0] = 32'hDEADBEEF;
    scan_dr({$urandom, $urandom}, 32, got);
`ifdef JTAG_TAP_DR_CAPTURE_IN_EN
    check_val("user0_capture", got, 64'hDEADBEEF);
`else
    check_val("user0_capture", got, 64'(w));
`endif

    // Reset in the middle of a USER_3 shift
    load_ir(5'h0B);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom));
    pulse_reset();
    step(1'b0, 1'b0);
    goto_tlr_rti();

    // Randomized mix of instructions, scans and free TMS walks
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NUM_DR; k++) intf.dr_in[k*DR_WIDTH +: DR_WIDTH] = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 3))
            0:       irv = IR_WIDTH'(1);
            1:       irv = '1;
            2:       irv = IR_WIDTH'(USER_BASE + $urandom_range(0, NUM_DR - 1));
            default: irv = IR_WIDTH'($urandom);
          endcase
          load_ir(irv);
        end
        1: scan_dr({$urandom, $urandom}, $urandom_range(1, 40), got);
        2: begin
          for (int i = 0; i < 15; i++) step(1'($urandom), 1'($urandom));
          goto_tlr_rti();
        end
        default: begin
          load_ir(IR_WIDTH'(USER_BASE + $urandom_range(0, NUM_DR - 1)));
          scan_dr({$urandom, $urandom}, $urandom_range(1, 40), got);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
